// File: rtl/digit_entry.sv
// Decimal keypad entry: collects BCD digits most-significant first, then on enter
// folds them into a binary value one digit per cycle and pulses result_valid.
module digit_entry #(
  parameter int MAX_DIGITS = 4,
  parameter int LEN        = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    digit_valid,
  input  logic [3:0]              digit,
  input  logic                    backspace,
  input  logic                    clear,
  input  logic                    enter,
  output logic                    busy,
  output logic [4*MAX_DIGITS-1:0] entry_bcd,
  output logic [2:0]              count,
  output logic [LEN-1:0]          result,
  output logic                    result_valid,
  output logic                    err
);

  localparam int             BW      = 4 * MAX_DIGITS;
  localparam logic [2:0]     MAX_CNT = 3'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_ENTRY,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_entry;
  logic [2:0]      r_count;
  logic [2:0]      r_idx;
  logic [LEN-1:0]  r_acc;
  logic [LEN-1:0]  r_result;
  logic            r_busy;
  logic            r_result_valid;
  logic            r_err;

  logic [BW-1:0]   w_shifted;
  logic [3:0]      w_nib;
  logic [LEN-1:0]  w_acc_next;

  // Digit under conversion, selected by idx from the most significant end down.
  assign w_shifted  = r_entry >> {r_idx, 2'b00};
  assign w_nib      = w_shifted[3:0];
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {{(LEN-4){1'b0}}, w_nib};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_ENTRY;
      r_entry        <= '0;
      r_count        <= '0;
      r_idx          <= '0;
      r_acc          <= '0;
      r_result       <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      case (r_state)
        S_ENTRY: begin
          if (clear) begin
            r_entry <= '0;
            r_count <= '0;
          end else if (enter) begin
            r_acc  <= '0;
            r_busy <= 1'b1;
            if (r_count != 3'd0) begin
              r_idx   <= r_count - 3'd1;
              r_state <= S_CONVERT;
            end else begin
              // Empty buffer converts straight to zero.
              r_result       <= '0;
              r_result_valid <= 1'b1;
              r_entry        <= '0;
              r_state        <= S_DONE;
            end
          end else if (backspace) begin
            if (r_count != 3'd0) begin
              r_entry <= {4'b0000, r_entry[BW-1:4]};
              r_count <= r_count - 3'd1;
            end
          end else if (digit_valid) begin
            if ((digit > 4'd9) || (r_count >= MAX_CNT)) begin
              r_err <= 1'b1;
            end else begin
              r_entry <= {r_entry[BW-5:0], digit};
              r_count <= r_count + 3'd1;
            end
          end
        end

        S_CONVERT: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx - 3'd1;
          // Publish on entry to DONE so result and its valid pulse share the DONE cycle.
          if (r_idx == 3'd0) begin
            r_result       <= w_acc_next;
            r_result_valid <= 1'b1;
            r_entry        <= '0;
            r_count        <= '0;
            r_state        <= S_DONE;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_ENTRY;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_ENTRY;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign entry_bcd    = r_entry;
  assign count        = r_count;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign err          = r_err;

endmodule

// File: tb/tb_digit_entry.sv
// Bench for digit_entry: directed keypad sequences plus random keypad traffic,
// compared against a digit-list model of the entry buffer.
module tb_digit_entry;
  localparam int MAXD = 4;
  localparam int LEN  = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic            digit_valid;
  logic [3:0]      digit;
  logic            backspace;
  logic            clear;
  logic            enter;
  logic            busy;
  logic [4*MAXD-1:0] entry_bcd;
  logic [2:0]      count;
  logic [LEN-1:0]  result;
  logic            result_valid;
  logic            err;

  int total = 0;
  int bad   = 0;

  int q[$];
  int m_result = 0;

  always #5 clk = ~clk;

  digit_entry #(.MAX_DIGITS(MAXD), .LEN(LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .backspace    (backspace),
    .clear        (clear),
    .enter        (enter),
    .busy         (busy),
    .entry_bcd    (entry_bcd),
    .count        (count),
    .result       (result),
    .result_valid (result_valid),
    .err          (err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value of the entered number: sum of digit * 10^position.
  function automatic int model_value();
    int v = 0;
    int p = 1;
    for (int i = q.size() - 1; i >= 0; i--) begin
      v += q[i] * p;
      p *= 10;
    end
    return v % (1 << LEN);
  endfunction

  function automatic logic [31:0] model_bcd();
    logic [31:0] e = '0;
    for (int i = 0; i < q.size(); i++)
      e |= 32'(q[i]) << (4 * (q.size() - 1 - i));
    return e;
  endfunction

  task automatic zero_inputs();
    digit_valid = 1'b0;
    digit       = 4'd0;
    backspace   = 1'b0;
    clear       = 1'b0;
    enter       = 1'b0;
  endtask

  task automatic junk_inputs();
    digit_valid = 1'($urandom);
    digit       = 4'($urandom);
    backspace   = 1'($urandom);
    clear       = 1'($urandom);
    enter       = 1'($urandom);
  endtask

  task automatic check_idle(input string tag, input bit exp_err);
    chk({tag, ".bcd"},   32'(entry_bcd),    model_bcd());
    chk({tag, ".count"}, 32'(count),        32'(q.size()));
    chk({tag, ".busy"},  32'(busy),         32'd0);
    chk({tag, ".rv"},    32'(result_valid), 32'd0);
    chk({tag, ".err"},   32'(err),          32'(exp_err));
    chk({tag, ".res"},   32'(result),       32'(m_result));
  endtask

  // One keypad cycle; an effective enter runs the whole conversion with
  // random input noise while busy.
  task automatic cyc(input string tag, input bit dv, input logic [3:0] d,
                     input bit bs, input bit clr, input bit ent);
    bit e_err = 1'b0;
    int val;
    int n;
    @(negedge clk);
    digit_valid = dv;
    digit       = d;
    backspace   = bs;
    clear       = clr;
    enter       = ent;
    if (!clr && ent) begin
      val = model_value();
      n   = q.size();
      @(posedge clk); #1; zero_inputs();
      for (int k = 1; k <= n + 1; k++) begin
        chk({tag, ".cbusy"}, 32'(busy),         32'd1);
        chk({tag, ".crv"},   32'(result_valid), 32'(k == n + 1));
        chk({tag, ".cerr"},  32'(err),          32'd0);
        if (k == n + 1) chk({tag, ".cres"}, 32'(result), 32'(val));
        else            chk({tag, ".chold"}, 32'(result), 32'(m_result));
        @(negedge clk); junk_inputs();
        @(posedge clk); #1; zero_inputs();
      end
      q.delete();
      m_result = val;
      check_idle(tag, 1'b0);
      return;
    end
    @(posedge clk); #1; zero_inputs();
    if (clr) q.delete();
    else if (bs) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (dv) begin
      if (d > 4'd9 || q.size() >= MAXD) e_err = 1'b1;
      else q.push_back(int'(d));
    end
    check_idle(tag, e_err);
  endtask

  task automatic key(input string tag, input logic [3:0] d);
    cyc(tag, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_enter(input string tag);
    cyc(tag, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    zero_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.bcd",   32'(entry_bcd),    32'd0);
    chk("rst.count", 32'(count),        32'd0);
    chk("rst.res",   32'(result),       32'd0);
    chk("rst.rv",    32'(result_valid), 32'd0);
    chk("rst.err",   32'(err),          32'd0);
    chk("rst.busy",  32'(busy),         32'd0);
    @(negedge clk); rst = 1'b0;

    // 1,2,3,4 then enter
    key("t1.d1", 4'd1); key("t1.d2", 4'd2); key("t1.d3", 4'd3); key("t1.d4", 4'd4);
    chk("t1.bcd",   32'(entry_bcd), 32'h1234);
    chk("t1.count", 32'(count),     32'd4);
    press_enter("t1.ent");
    chk("t1.res",   32'(result),    32'd1234);

    // 9,8,7, backspace, 5
    key("t2.d9", 4'd9); key("t2.d8", 4'd8); key("t2.d7", 4'd7);
    cyc("t2.bs", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    key("t2.d5", 4'd5);
    chk("t2.bcd", 32'(entry_bcd), 32'h985);
    press_enter("t2.ent");
    chk("t2.res", 32'(result), 32'd985);
    cyc("t2.bs0", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

    // overflow of the buffer, then bad digits back-to-back
    key("t3.a", 4'd9); key("t3.b", 4'd9); key("t3.c", 4'd9); key("t3.d", 4'd9);
    key("t3.over", 4'd1);
    idle("t3.idle");
    chk("t3.bcd", 32'(entry_bcd), 32'h9999);
    press_enter("t3.ent");
    chk("t3.res", 32'(result), 32'd9999);
    key("t3.hexA", 4'hA);
    key("t3.hexB", 4'hB);
    idle("t3.idle2");

    // empty enter, clear beats enter
    press_enter("t4.empty");
    chk("t4.res", 32'(result), 32'd0);
    key("t4.d3", 4'd3); key("t4.d4", 4'd4);
    cyc("t4.clrent", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    idle("t4.after");

    // leading zeros
    key("t5.z1", 4'd0); key("t5.z2", 4'd0); key("t5.d7", 4'd7);
    chk("t5.count", 32'(count), 32'd3);
    press_enter("t5.ent");
    chk("t5.res", 32'(result), 32'd7);

    // reset during conversion
    key("t6.d5", 4'd5); key("t6.d6", 4'd6); key("t6.d7", 4'd7); key("t6.d8", 4'd8);
    @(negedge clk); enter = 1'b1;
    @(posedge clk); #1; zero_inputs();
    chk("t6.busy1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("t6.rv2", 32'(result_valid), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_result = 0;
    check_idle("t6.rst", 1'b0);
    for (int i = 0; i < 6; i++) idle("t6.quiet");
    key("t6.alive", 4'd3);

    // random keypad traffic
    for (int i = 0; i < 400; i++) begin
      int sel = $urandom_range(0, 99);
      if (sel < 55)      key("rnd.key", 4'($urandom_range(0, 11)));
      else if (sel < 70) cyc("rnd.bs", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      else if (sel < 75) cyc("rnd.clr", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      else if (sel < 85) press_enter("rnd.ent");
      else cyc("rnd.mix", 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
